// File: rtl/tlb_op_sequencer.sv
// Sequences CP0 TLB ops (TLBP/TLBR/TLBWI/TLBWR) from MEM into the TLB array, one strobe per op.
// Also owns the CP0 Random register and the post-write refetch flush.
module tlb_op_sequencer #(
   parameter int TLB_LINE_NUM      = 32,
   parameter int LOG2_TLB_LINE_NUM = 5
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         req_valid,
   input  logic [1:0]                   req_op,
   input  logic [31:0]                  req_pc,
   output logic                         req_ready,
   input  logic                         req_kill,
   input  logic [LOG2_TLB_LINE_NUM-1:0] cp0_wired,
   input  logic                         cp0_wired_we,
   output logic [31:0]                  random_out,
   output logic                         tlb_p,
   output logic                         tlb_r,
   output logic                         tlb_wi,
   output logic                         tlb_wr,
   output logic [LOG2_TLB_LINE_NUM-1:0] tlb_wr_index,
   output logic                         cp0_index_we,
   output logic                         cp0_tlbr_we,
   output logic                         stall,
   output logic                         flush,
   output logic [31:0]                  flush_pc,
   output logic                         done
);

   localparam logic [LOG2_TLB_LINE_NUM-1:0] RAND_MAX = LOG2_TLB_LINE_NUM'(TLB_LINE_NUM - 1);

   localparam logic [1:0] OP_TLBP  = 2'b00;
   localparam logic [1:0] OP_TLBR  = 2'b01;
   localparam logic [1:0] OP_TLBWI = 2'b10;
   localparam logic [1:0] OP_TLBWR = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_EXEC  = 2'd1,
      S_FLUSH = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t                         state;
   state_t                         state_nxt;
   logic [1:0]                     op;
   logic [LOG2_TLB_LINE_NUM-1:0]   random;
   logic                           accept;
   logic                           issue;

   assign accept     = (state == S_IDLE) && req_valid && !req_kill;
   // Reset in the EXEC cycle suppresses the strobe so an aborted op never touches the TLB.
   assign issue      = (state == S_EXEC) && !req_kill && !rst;
   assign random_out = {{(32 - LOG2_TLB_LINE_NUM){1'b0}}, random};

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (accept) state_nxt = S_EXEC;
         S_EXEC: begin
            if (req_kill)    state_nxt = S_IDLE;
            else if (op[1])  state_nxt = S_FLUSH;
            else             state_nxt = S_DONE;
         end
         S_FLUSH: state_nxt = S_IDLE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      req_ready    = 1'b0;
      stall        = 1'b0;
      tlb_p        = 1'b0;
      tlb_r        = 1'b0;
      tlb_wi       = 1'b0;
      tlb_wr       = 1'b0;
      cp0_index_we = 1'b0;
      cp0_tlbr_we  = 1'b0;
      flush        = 1'b0;
      done         = 1'b0;
      case (state)
         S_IDLE: begin
            req_ready = 1'b1;
            stall     = req_valid;
         end
         S_EXEC: begin
            stall = !req_kill;
            if (issue) begin
               case (op)
                  OP_TLBP:  begin tlb_p = 1'b1; cp0_index_we = 1'b1; end
                  OP_TLBR:  begin tlb_r = 1'b1; cp0_tlbr_we  = 1'b1; end
                  OP_TLBWI: tlb_wi = 1'b1;
                  OP_TLBWR: tlb_wr = 1'b1;
                  default:  ;
               endcase
            end
         end
         S_FLUSH: begin
            flush = 1'b1;
            done  = 1'b1;
         end
         S_DONE:  done = 1'b1;
         default: ;
      endcase
   end

   // Op, refetch target and the TLBWR index are frozen at accept so later Random motion is harmless.
   always_ff @(posedge clk) begin
      if (rst) begin
         op           <= OP_TLBP;
         flush_pc     <= 32'd0;
         tlb_wr_index <= '0;
      end else if (accept) begin
         op           <= req_op;
         flush_pc     <= req_pc + 32'd4;
         tlb_wr_index <= random;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || cp0_wired_we)      random <= RAND_MAX;
      else if (cp0_wired >= RAND_MAX) random <= RAND_MAX;
      else if (random <= cp0_wired) random <= RAND_MAX;
      else                          random <= random - 1'b1;
   end

endmodule

// File: tb/tb_tlb_op_sequencer.sv
// Bench for tlb_op_sequencer: per-scenario tasks plus a completion scoreboard checked on done.
module tb_tlb_op_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic [1:0]  req_op;
   logic [31:0] req_pc;
   logic        req_ready;
   logic        req_kill;
   logic [4:0]  cp0_wired;
   logic        cp0_wired_we;
   logic [31:0] random_out;
   logic        tlb_p, tlb_r, tlb_wi, tlb_wr;
   logic [4:0]  tlb_wr_index;
   logic        cp0_index_we, cp0_tlbr_we;
   logic        stall, flush, done;
   logic [31:0] flush_pc;

   typedef struct packed {
      logic        is_flush;
      logic [31:0] pc;
   } exp_t;

   exp_t sb[$];
   int   vectors = 0;
   int   miscompares = 0;

   always #5 clk = ~clk;

   tlb_op_sequencer #(.TLB_LINE_NUM(32), .LOG2_TLB_LINE_NUM(5)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op), .req_pc(req_pc),
      .req_ready(req_ready), .req_kill(req_kill), .cp0_wired(cp0_wired),
      .cp0_wired_we(cp0_wired_we), .random_out(random_out), .tlb_p(tlb_p), .tlb_r(tlb_r),
      .tlb_wi(tlb_wi), .tlb_wr(tlb_wr), .tlb_wr_index(tlb_wr_index),
      .cp0_index_we(cp0_index_we), .cp0_tlbr_we(cp0_tlbr_we), .stall(stall),
      .flush(flush), .flush_pc(flush_pc), .done(done)
   );

   // Completion monitor: every done must match the oldest outstanding op.
   always @(negedge clk) begin
      if (!rst && done) begin
         vectors++;
         if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL sb_spurious_done got done=1 with no op outstanding, required none");
         end else begin
            exp_t e;
            e = sb.pop_front();
            if (flush !== e.is_flush || (e.is_flush && flush_pc !== e.pc)) begin
               miscompares++;
               $display("FAIL sb_completion got flush=%b pc=%h, required flush=%b pc=%h",
                        flush, flush_pc, e.is_flush, e.pc);
            end
         end
      end
   end

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      logic [4:0] exp_rand;
      rst = 1'b1;
      repeat (2) step();
      rst = 1'b0;
      exp_rand = 5'd31;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         vectors++;
         if (random_out !== {27'd0, exp_rand}) begin
            miscompares++;
            $display("FAIL reset_random cyc=%0d got=%0d required=%0d", i, random_out, exp_rand);
         end
         vectors++;
         if ({tlb_p, tlb_r, tlb_wi, tlb_wr, cp0_index_we, cp0_tlbr_we, stall, flush, done,
              flush_pc, tlb_wr_index} !== '0 || req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_outputs cyc=%0d got strobes/we=%b ready=%b fpc=%h idx=%0d, required 0/1/0/0",
                     i, {tlb_p, tlb_r, tlb_wi, tlb_wr, cp0_index_we, cp0_tlbr_we, stall, flush, done},
                     req_ready, flush_pc, tlb_wr_index);
         end
         step();
         exp_rand = (exp_rand == 5'd0) ? 5'd31 : exp_rand - 5'd1;
      end
   endtask

   task automatic test_tlbp;
      req_valid = 1'b1; req_op = 2'b00; req_pc = 32'h8000_0100;
      @(negedge clk);
      vectors++;
      if (req_ready !== 1'b1 || stall !== 1'b1 || tlb_p !== 1'b0) begin
         miscompares++;
         $display("FAIL tlbp_t got ready=%b stall=%b tlb_p=%b, required 1 1 0", req_ready, stall, tlb_p);
      end
      sb.push_back('{is_flush: 1'b0, pc: 32'h0});
      step();
      req_valid = 1'b0;
      @(negedge clk);
      vectors++;
      if ({tlb_p, cp0_index_we, stall, tlb_r, tlb_wi, tlb_wr, cp0_tlbr_we, done} !== 8'b1110_0000) begin
         miscompares++;
         $display("FAIL tlbp_t1 got p/iwe/stall/r/wi/wr/rwe/done=%b, required 11100000",
                  {tlb_p, cp0_index_we, stall, tlb_r, tlb_wi, tlb_wr, cp0_tlbr_we, done});
      end
      step();
      @(negedge clk);
      vectors++;
      if ({done, flush, stall, tlb_p, cp0_index_we} !== 5'b10000) begin
         miscompares++;
         $display("FAIL tlbp_t2 got done/flush/stall/p/iwe=%b, required 10000",
                  {done, flush, stall, tlb_p, cp0_index_we});
      end
      step();
   endtask

   task automatic test_tlbwi;
      req_valid = 1'b1; req_op = 2'b10; req_pc = 32'hBFC0_0FFC;
      @(negedge clk);
      sb.push_back('{is_flush: 1'b1, pc: 32'hBFC0_1000});
      step();
      req_valid = 1'b0;
      @(negedge clk);
      vectors++;
      if ({tlb_wi, tlb_p, tlb_r, tlb_wr, stall} !== 5'b10001) begin
         miscompares++;
         $display("FAIL tlbwi_t1 got wi/p/r/wr/stall=%b, required 10001", {tlb_wi, tlb_p, tlb_r, tlb_wr, stall});
      end
      step();
      @(negedge clk);
      vectors++;
      if (flush !== 1'b1 || flush_pc !== 32'hBFC0_1000 || stall !== 1'b0) begin
         miscompares++;
         $display("FAIL tlbwi_t2 got flush=%b pc=%h stall=%b, required 1 bfc01000 0", flush, flush_pc, stall);
      end
      step();
   endtask

   task automatic test_tlbwr_random;
      bit found = 0;
      cp0_wired = 5'd8;
      step();
      for (int i = 0; i < 40 && !found; i++) begin
         @(negedge clk);
         if (random_out == 32'd8) found = 1;
         else step();
      end
      vectors++;
      if (!found) begin
         miscompares++;
         $display("FAIL tlbwr_wait got no random=8 within 40 cycles, required random=8");
      end else begin
         req_valid = 1'b1; req_op = 2'b11; req_pc = 32'h0000_1230;
         sb.push_back('{is_flush: 1'b1, pc: 32'h0000_1234});
         step();
         req_valid = 1'b0;
         @(negedge clk);
         vectors++;
         if (tlb_wr !== 1'b1 || tlb_wr_index !== 5'd8 || random_out !== 32'd31) begin
            miscompares++;
            $display("FAIL tlbwr_exec got wr=%b idx=%0d random=%0d, required 1 8 31", tlb_wr, tlb_wr_index, random_out);
         end
         step();
         @(negedge clk);
         vectors++;
         if (flush !== 1'b1 || tlb_wr !== 1'b0) begin
            miscompares++;
            $display("FAIL tlbwr_flush got flush=%b wr=%b, required 1 0", flush, tlb_wr);
         end
         step();
      end
   endtask

   task automatic test_kill;
      req_valid = 1'b1; req_op = 2'b01; req_pc = 32'h0000_2000;
      step();
      req_valid = 1'b0; req_kill = 1'b1;
      @(negedge clk);
      vectors++;
      if (tlb_r !== 1'b0 || cp0_tlbr_we !== 1'b0) begin
         miscompares++;
         $display("FAIL kill_exec got tlb_r=%b rwe=%b, required 0 0", tlb_r, cp0_tlbr_we);
      end
      step();
      req_kill = 1'b0;
      @(negedge clk);
      vectors++;
      if (req_ready !== 1'b1 || done !== 1'b0 || stall !== 1'b0) begin
         miscompares++;
         $display("FAIL kill_idle got ready=%b done=%b stall=%b, required 1 0 0", req_ready, done, stall);
      end
      step();
   endtask

   task automatic test_back_to_back;
      req_valid = 1'b1; req_op = 2'b01; req_pc = 32'h0000_3000;
      sb.push_back('{is_flush: 1'b0, pc: 32'h0});
      step();
      @(negedge clk);
      vectors++;
      if (tlb_r !== 1'b1 || cp0_tlbr_we !== 1'b1 || req_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL b2b_exec got r=%b rwe=%b ready=%b, required 1 1 0", tlb_r, cp0_tlbr_we, req_ready);
      end
      step();
      @(negedge clk);
      vectors++;
      if (done !== 1'b1 || req_ready !== 1'b0 || tlb_r !== 1'b0) begin
         miscompares++;
         $display("FAIL b2b_done got done=%b ready=%b r=%b, required 1 0 0", done, req_ready, tlb_r);
      end
      step();
      @(negedge clk);
      vectors++;
      if (req_ready !== 1'b1 || stall !== 1'b1) begin
         miscompares++;
         $display("FAIL b2b_reaccept got ready=%b stall=%b, required 1 1", req_ready, stall);
      end
      sb.push_back('{is_flush: 1'b0, pc: 32'h0});
      step();
      req_valid = 1'b0;
      @(negedge clk);
      vectors++;
      if (tlb_r !== 1'b1) begin
         miscompares++;
         $display("FAIL b2b_exec2 got r=%b, required 1", tlb_r);
      end
      repeat (2) step();
   endtask

   task automatic test_wired_we_and_rst;
      bit found = 0;
      cp0_wired = 5'd0;
      for (int i = 0; i < 40 && !found; i++) begin
         @(negedge clk);
         if (random_out == 32'd12) found = 1;
         else step();
      end
      vectors++;
      if (!found) begin
         miscompares++;
         $display("FAIL wired_wait got no random=12 within 40 cycles, required random=12");
      end
      cp0_wired_we = 1'b1;
      step();
      cp0_wired_we = 1'b0;
      @(negedge clk);
      vectors++;
      if (random_out !== 32'd31) begin
         miscompares++;
         $display("FAIL wired_we_random got=%0d required=31", random_out);
      end
      step();
      req_valid = 1'b1; req_op = 2'b10; req_pc = 32'h0000_4000;
      step();
      req_valid = 1'b0; rst = 1'b1;
      @(negedge clk);
      vectors++;
      if (tlb_wi !== 1'b0) begin
         miscompares++;
         $display("FAIL rst_exec_strobe got tlb_wi=%b required 0", tlb_wi);
      end
      step();
      rst = 1'b0;
      @(negedge clk);
      vectors++;
      if ({req_ready, tlb_wi, flush, done, stall} !== 5'b10000 || random_out !== 32'd31) begin
         miscompares++;
         $display("FAIL rst_after got ready/wi/flush/done/stall=%b random=%0d, required 10000 31",
                  {req_ready, tlb_wi, flush, done, stall}, random_out);
      end
      step();
   endtask

   initial begin
      rst = 1'b1; req_valid = 1'b0; req_op = 2'b00; req_pc = 32'h0;
      req_kill = 1'b0; cp0_wired = 5'd0; cp0_wired_we = 1'b0;
      #1;
      test_reset();
      test_tlbp();
      test_tlbwi();
      test_tlbwr_random();
      test_kill();
      test_back_to_back();
      test_wired_we_and_rst();
      repeat (3) step();
      vectors++;
      if (sb.size() != 0) begin
         miscompares++;
         $display("FAIL sb_drain got %0d ops outstanding, required 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
